sipo_frame_ctrl: RTL and testbench

Frame controller that sequences a serial-in/parallel-out shift register.
- Waits for a frame start, then counts WIDTH qualified serial bits into the shifter.
- Presents the completed word on a valid/ready output handshake.
- Flags overrun when a new frame starts while the previous word is unconsumed.
- Sits between a serial bit source (strobed by sin_en) and a parallel word consumer.

---
 rtl/sipo_frame_ctrl_pkg.sv | 12 +
 rtl/sipo_shift_reg.sv | 29 ++
 rtl/sipo_frame_ctrl.sv | 114 +++++++++++
 tb/tb_sipo_frame_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared definitions for the SIPO frame controller: FSM state encoding and default word length.
package sipo_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StHold  = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 4;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in/parallel-out shift register with synchronous clear and shift enable.
module sipo_shift_reg #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // MSB_FIRST=0 enters at the top and drifts down, so the first bit ends in bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (clr) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= MSB_FIRST ? {q_q[WIDTH-2:0], sin} : {sin, q_q[WIDTH-1:1]};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: collects WIDTH strobed serial bits, then offers the word on a
// valid/ready handshake with a sticky overrun flag for starts that arrive too early.
module sipo_frame_ctrl
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] sh_q, full_word;
  logic             valid_q, busy_q;
  logic             ovr_q, ovr_d;
  logic             sh_clr, sh_en;

  sipo_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (sh_clr),
    .en   (sh_en),
    .sin  (sin),
    .q    (sh_q)
  );

  // Word as it will look once the current bit is shifted in; lets dout load on the last bit.
  assign full_word = MSB_FIRST ? {sh_q[WIDTH-2:0], sin} : {sin, sh_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ovr_d   = ovr_q & ~clr_err;
    sh_clr  = 1'b0;
    sh_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StShift;
          cnt_d   = '0;
          sh_clr  = 1'b1;
        end
      end
      StShift: begin
        if (sin_en) begin
          sh_en = 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StHold;
            dout_d  = full_word;
            cnt_d   = CntW'(WIDTH);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        if (dout_ready) begin
          if (start) begin
            state_d = StShift;
            cnt_d   = '0;
            sh_clr  = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else if (start) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= (state_d == StHold);
      busy_q  <= (state_d != StIdle);
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench: directed frames plus random traffic against a bit-queue reference model,
// with LSB-first and MSB-first instances sharing the same stimulus.
module tb_sipo_frame_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin = 1'b0;
  logic         sin_en = 1'b0;
  logic         start = 1'b0;
  logic         dout_ready = 1'b0;
  logic         clr_err = 1'b0;
  logic [W-1:0] dout_a, dout_b;
  logic         valid_a, valid_b, busy_a, busy_b, ovr_a, ovr_b;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit           m_collect, m_pending, m_ovr;
  bit           m_bits[$];
  logic [W-1:0] m_word_lsb, m_word_msb;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_en    (sin_en),
    .start     (start),
    .dout      (dout_a),
    .dout_valid(valid_a),
    .dout_ready(dout_ready),
    .busy      (busy_a),
    .overrun   (ovr_a),
    .clr_err   (clr_err)
  );

  sipo_frame_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .sin_en    (sin_en),
    .start     (start),
    .dout      (dout_b),
    .dout_valid(valid_b),
    .dout_ready(dout_ready),
    .busy      (busy_b),
    .overrun   (ovr_b),
    .clr_err   (clr_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame rules applied to the inputs seen at one rising edge.
  task automatic model_update();
    bit set_ovr;
    set_ovr = 1'b0;
    if (!rst_n) begin
      m_collect  = 1'b0;
      m_pending  = 1'b0;
      m_ovr      = 1'b0;
      m_word_lsb = '0;
      m_word_msb = '0;
      m_bits.delete();
    end else begin
      if (m_collect) begin
        if (sin_en) begin
          m_bits.push_back(sin);
          if (m_bits.size() == W) begin
            for (int i = 0; i < W; i++) begin
              m_word_lsb[i]       = m_bits[i];
              m_word_msb[W-1-i]   = m_bits[i];
            end
            m_collect = 1'b0;
            m_pending = 1'b1;
          end
        end
      end else if (m_pending) begin
        if (dout_ready) begin
          m_pending = 1'b0;
          if (start) begin
            m_collect = 1'b1;
            m_bits.delete();
          end
        end else if (start) begin
          set_ovr = 1'b1;
        end
      end else if (start) begin
        m_collect = 1'b1;
        m_bits.delete();
      end
      if (set_ovr) m_ovr = 1'b1;
      else if (clr_err) m_ovr = 1'b0;
    end
  endtask

  task automatic step(input logic s, input logic en, input logic st, input logic rdy,
                      input logic clr, input logic rn);
    sin        = s;
    sin_en     = en;
    start      = st;
    dout_ready = rdy;
    clr_err    = clr;
    rst_n      = rn;
    @(posedge clk);
    model_update();
    #1;
    check_eq("dout_lsb",  32'(dout_a),  32'(m_word_lsb));
    check_eq("dout_msb",  32'(dout_b),  32'(m_word_msb));
    check_eq("valid_lsb", 32'(valid_a), 32'(m_pending));
    check_eq("valid_msb", 32'(valid_b), 32'(m_pending));
    check_eq("busy_lsb",  32'(busy_a),  32'(m_collect | m_pending));
    check_eq("busy_msb",  32'(busy_b),  32'(m_collect | m_pending));
    check_eq("ovr_lsb",   32'(ovr_a),   32'(m_ovr));
    check_eq("ovr_msb",   32'(ovr_b),   32'(m_ovr));
  endtask

  task automatic send_bits(input logic [W-1:0] bits_in_order);
    for (int i = W - 1; i >= 0; i--) step(bits_in_order[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [6:0] en_pat;
    logic [3:0] gap_bits;
    int         k;

    // Reset from arbitrary activity
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("rst_dout",  32'(dout_a),  32'h0);
    check_eq("rst_valid", 32'(valid_a), 32'h0);
    check_eq("rst_busy",  32'(busy_a),  32'h0);
    check_eq("rst_ovr",   32'(ovr_a),   32'h0);

    // Basic frame: bits 1,0,1,1
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    send_bits(4'b1011);
    check_eq("basic_lsb",   32'(dout_a),  32'hD);
    check_eq("basic_msb",   32'(dout_b),  32'hB);
    check_eq("basic_valid", 32'(valid_a), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("accept_valid", 32'(valid_a), 32'h0);
    check_eq("accept_busy",  32'(busy_a),  32'h0);
    check_eq("accept_keep",  32'(dout_a),  32'hD);

    // Gapped strobe: en 1,0,1,0,0,1,1 carrying 0,1,1,0
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    en_pat   = 7'b1010011;
    gap_bits = 4'b0110;
    k = 3;
    for (int i = 6; i >= 0; i--) begin
      if (en_pat[i]) begin
        step(gap_bits[k], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        k--;
      end else begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
    end
    check_eq("gap_lsb", 32'(dout_a), 32'h6);

    // Backpressure and overrun
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("ovr_set",   32'(ovr_a),   32'h1);
    check_eq("ovr_dout",  32'(dout_a),  32'h6);
    check_eq("ovr_valid", 32'(valid_a), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("ovr_clr", 32'(ovr_a), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check_eq("ovr_set_wins", 32'(ovr_a), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Back-to-back: accept and restart in the same cycle, then 0,0,0,1
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("b2b_busy", 32'(busy_a), 32'h1);
    check_eq("b2b_ovr",  32'(ovr_a),  32'h0);
    send_bits(4'b0001);
    check_eq("b2b_lsb", 32'(dout_a), 32'h8);
    check_eq("b2b_msb", 32'(dout_b), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Reset mid-frame, then a clean frame
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("midrst_dout", 32'(dout_a), 32'h0);
    check_eq("midrst_busy", 32'(busy_a), 32'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    send_bits(4'b1011);
    check_eq("post_lsb", 32'(dout_a), 32'hD);
    check_eq("post_msb", 32'(dout_b), 32'hB);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(1)),
           1'($urandom_range(99) < 60),
           1'($urandom_range(99) < 20),
           1'($urandom_range(99) < 50),
           1'($urandom_range(99) < 10),
           1'($urandom_range(99) >= 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
